// File: rtl/seq_divider_16.sv
// -----------------------------------------------------------------------------
// seq_divider_16
//   Iterative radix-2 restoring divider. One quotient bit is resolved per clock
//   with a (WIDTH+1)-bit trial subtraction, and operations use a start/done
//   handshake.
//
//   Optional build macro: SIGNED_DIV_EN
//     Undefined : unsigned operands, done 16 cycles after start is accepted.
//     Defined   : two's-complement operands, truncate-toward-zero results,
//                 one extra sign-correction cycle (FIX), done after 17 cycles.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       operation request, sampled only while busy = 0
//   dividend    numerator, captured on the accepting edge
//   divisor     denominator, captured on the accepting edge
//   busy        high from the accepting edge until done drops
//   done        one-cycle pulse when the results are valid
//   quotient    result, held until the next operation completes
//   remainder   result, held until the next operation completes
//   div_by_zero set with done when divisor == 0; updated on the accepting edge
// -----------------------------------------------------------------------------
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q;      // partial remainder
  logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;    // captured divisor (magnitude in signed builds)
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

`ifdef SIGNED_DIV_EN
  logic             neg_quo_q;  // operand signs differ
  logic             neg_rem_q;  // dividend negative

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of a two's-complement value; the most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction
`endif

  // Trial subtraction: a borrow (MSB set) means the divisor did not fit.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    trial = {r_q, q_q[WIDTH-1]} - {1'b0, dvs_q};
    r_d   = trial[WIDTH] ? {r_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
    q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        // Accept: capture operands, or short-circuit a zero divisor.
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            dbz_q  <= (divisor == '0);
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cnt_q   <= CNT_W'(WIDTH);
              r_q     <= '0;
`ifdef SIGNED_DIV_EN
              q_q       <= magnitude(dividend);
              dvs_q     <= magnitude(divisor);
              neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_rem_q <= dividend[WIDTH-1];
`else
              q_q     <= dividend;
              dvs_q   <= divisor;
`endif
              state_q <= RUN;
            end
          end
        end
        // Iterate: one quotient bit per edge.
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            quo_q   <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= FIN;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        // Sign correction of the unsigned core result.
        FIX: begin
          quo_q   <= neg_quo_q ? negate(q_q) : q_q;
          rem_q   <= neg_rem_q ? negate(r_q) : r_q;
          done_q  <= 1'b1;
          state_q <= FIN;
        end
`endif
        // Done pulse cycle; release busy on the way back to IDLE.
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed testbench for seq_divider_16. Inputs are driven and outputs sampled
// 1 time unit after the rising clock edge.
module tb_seq_divider_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for exactly one accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = 16'h0;
    divisor = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (quotient !== 16'h0 || remainder !== 16'h0) begin
      fails++; $display("FAIL reset_results: got q=%h r=%h want 0/0", quotient, remainder);
    end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    int pulses;
    start_op(16'd1000, 16'd7);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(n);
    tests++; if (n != LAT) begin fails++; $display("FAIL basic_latency: got %0d want %0d", n, LAT); end
    tests++; if (quotient !== 16'd142) begin fails++; $display("FAIL basic_quot: got %0d want 142", quotient); end
    tests++; if (remainder !== 16'd6) begin fails++; $display("FAIL basic_rem: got %0d want 6", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL basic_single_pulse: got %0d extra pulses want 0", pulses); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_extremes();
    int n;
    start_op(16'hFFFF, 16'd1);
    wait_done(n);
    tests++; if (quotient !== 16'hFFFF || remainder !== 16'h0) begin
      fails++; $display("FAIL max_by_one: got q=%h r=%h want FFFF/0000", quotient, remainder);
    end
    @(posedge clk); #1;
    start_op(16'd5, 16'hFFFF);
    wait_done(n);
`ifdef SIGNED_DIV_EN
    tests++; if (quotient !== 16'hFFFB || remainder !== 16'h0) begin
      fails++; $display("FAIL small_by_max: got q=%h r=%h want FFFB/0000", quotient, remainder);
    end
`else
    tests++; if (quotient !== 16'h0 || remainder !== 16'd5) begin
      fails++; $display("FAIL small_by_max: got q=%h r=%h want 0000/0005", quotient, remainder);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int n;
    start_op(16'd1234, 16'd0);
    wait_done(n);
    tests++; if (n != 0) begin fails++; $display("FAIL dbz_latency: got %0d want 0", n); end
    tests++; if (quotient !== 16'hFFFF || remainder !== 16'd1234) begin
      fails++; $display("FAIL dbz_results: got q=%h r=%0d want FFFF/1234", quotient, remainder);
    end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL dbz_release: got busy=%b done=%b want 0/0", busy, done);
    end
    // Next start clears the flag at once but keeps the old results until done.
    start_op(16'd10, 16'd3);
    tests++; if (div_by_zero !== 1'b0 || quotient !== 16'hFFFF) begin
      fails++; $display("FAIL dbz_hold: got dbz=%b q=%h want 0/FFFF", div_by_zero, quotient);
    end
    wait_done(n);
    tests++; if (quotient !== 16'd3 || remainder !== 16'd1) begin
      fails++; $display("FAIL ten_by_three: got q=%0d r=%0d want 3/1", quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_reset();
    int n;
    start_op(16'd100, 16'd3);
    repeat (4) begin @(posedge clk); #1; end
    start_op(16'd9, 16'd9);
    tests++; if (busy !== 1'b1 || quotient !== 16'd3) begin
      fails++; $display("FAIL busy_ignore: got busy=%b q=%0d want 1/3", busy, quotient);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL abort_reset: got busy=%b done=%b q=%h r=%h dbz=%b want all 0", busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_during_rst: busy got %b want 0", busy); end
    start_op(16'd9, 16'd9);
    wait_done(n);
    tests++; if (n != LAT || quotient !== 16'd1 || remainder !== 16'd0) begin
      fails++; $display("FAIL after_abort: got lat=%0d q=%0d r=%0d want %0d/1/0", n, quotient, remainder, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int last;
    int got;
`ifdef SIGNED_DIV_EN
    logic [15:0] exp_q = 16'hFF82;
    logic [15:0] exp_r = 16'hFFDA;
    int          exp_gap = 19;
`else
    logic [15:0] exp_q = 16'd406;
    logic [15:0] exp_r = 16'd62;
    int          exp_gap = 18;
`endif
    dividend = 16'd50000;
    divisor  = 16'd123;
    start    = 1'b1;
    cyc = 0;
    last = -1;
    got = 0;
    while (got < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        tests++; if (quotient !== exp_q || remainder !== exp_r) begin
          fails++; $display("FAIL b2b_result%0d: got q=%h r=%h want %h/%h", got, quotient, remainder, exp_q, exp_r);
        end
        if (last >= 0) begin
          tests++; if (cyc - last != exp_gap) begin
            fails++; $display("FAIL b2b_spacing%0d: got %0d want %0d", got, cyc - last, exp_gap);
          end
        end
        last = cyc;
        got++;
      end
    end
    start = 1'b0;
    tests++; if (got != 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", got); end
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    int n;
    start_op(16'hFFF9, 16'd2);
    wait_done(n);
    tests++; if (n != 17 || quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin
      fails++; $display("FAIL signed_neg7_2: got lat=%0d q=%h r=%h want 17/FFFD/FFFF", n, quotient, remainder);
    end
    @(posedge clk); #1;
    start_op(16'h8000, 16'hFFFF);
    wait_done(n);
    tests++; if (quotient !== 16'h8000 || remainder !== 16'h0) begin
      fails++; $display("FAIL signed_overflow: got q=%h r=%h want 8000/0000", quotient, remainder);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_abort_reset();
    test_back_to_back();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
